// File: rtl/gate_arbiter_pkg.sv
// Shared types for the parking-lot gate arbiter: FSM state encoding,
// direction encoding (matches the occupancy counter's updown sense),
// default counter width and a timer sizing helper.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IN  = 2'd1,
    GRANT_OUT = 2'd2,
    CLEAR     = 2'd3
  } state_t;

  // 1 = increment (entry), 0 = decrement (exit)
  typedef enum logic {
    DIR_OUT = 1'b0,
    DIR_IN  = 1'b1
  } dir_t;

  localparam int DEF_CNT_W = 3;

  // Bits needed for a timer that must reach max(a, b) - 1.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/gate_arbiter_if.sv
// Request / pass / gate-command bundle between the parking-lot FSM side
// and the gate arbiter. The wrong_way alarm exists only when
// WRONG_WAY_ALARM_EN is defined.
//
// Handshake: req_in / req_out are levels held by the requester; a grant is
// ended only by a one-cycle car_in / car_out pulse or by the grant timeout.
// cnt_en is a one-cycle strobe and cnt_up is meaningful only while cnt_en=1.
interface gate_arbiter_if import parking_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             req_in;
  logic             req_out;
  logic             car_in;
  logic             car_out;
  logic [CNT_W-1:0] count;
  logic             gate_up;
  logic             grant_in;
  logic             grant_out;
  logic             cnt_en;
  logic             cnt_up;
  logic             full;
  logic             empty;
  logic             timeout_err;
  state_t           state;
`ifdef WRONG_WAY_ALARM_EN
  logic             wrong_way;
`endif

  // Requester / counter side
  modport master (
    output req_in, req_out, car_in, car_out, count,
    input  gate_up, grant_in, grant_out, cnt_en, cnt_up, full, empty,
`ifdef WRONG_WAY_ALARM_EN
    input  wrong_way,
`endif
    input  timeout_err, state
  );

  // Arbiter side
  modport slave (
    input  req_in, req_out, car_in, car_out, count,
    output gate_up, grant_in, grant_out, cnt_en, cnt_up, full, empty,
`ifdef WRONG_WAY_ALARM_EN
    output wrong_way,
`endif
    output timeout_err, state
  );

endinterface

// File: rtl/gate_arbiter_timer.sv
// gate_timer: synchronous up-counter with load-zero and a terminal-count
// compare against a runtime limit. One instance serves both the grant
// window and the post-grant clear holdoff.
module gate_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         at_limit
);

  logic [W-1:0] value;

  // Count up every cycle unless told to restart from zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else begin
      value <= value + 1'b1;
    end
  end

  assign at_limit = (value == limit);

endmodule

// File: rtl/gate_arbiter.sv
// gate_arbiter: shares one barrier gate between entry and exit requesters.
// Grants one direction at a time (round-robin on ties), raises the gate,
// waits for the pass pulse, strobes the occupancy counter, then holds the
// gate closed for a clear period before arbitrating again.
// Optional: define WRONG_WAY_ALARM_EN to add the sticky wrong_way output.
module gate_arbiter import parking_pkg::*; #(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int CAPACITY     = 7,
  parameter int OPEN_CYCLES  = 1000,
  parameter int CLEAR_CYCLES = 50
) (
  input  logic          clk,
  input  logic          reset,
  gate_arbiter_if.slave bus
);

  localparam int               TW        = timer_width(OPEN_CYCLES, CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
  localparam logic [TW-1:0]    OPEN_LIM  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]    CLEAR_LIM = TW'(CLEAR_CYCLES - 1);

  state_t        state;
  dir_t          last_srv;
  logic          gate_up, grant_in, grant_out, cnt_en, cnt_up, timeout_err;
  logic          vin, vout, pick_in, pick_out;
  logic          grant_phase, pass, timer_clr, at_limit;
  logic [TW-1:0] timer_limit;

  // Occupancy flags follow count directly
  assign bus.full  = (bus.count >= CAP_V);
  assign bus.empty = (bus.count == '0);

  // Eligibility and round-robin pick; only consulted in IDLE
  assign vin      = bus.req_in  & ~bus.full;
  assign vout     = bus.req_out & ~bus.empty;
  assign pick_in  = vin & (~vout | (last_srv == DIR_OUT));
  assign pick_out = vout & ~pick_in;

  // A pass counts only in the direction currently granted
  assign grant_phase = (state == GRANT_IN) || (state == GRANT_OUT);
  assign pass        = ((state == GRANT_IN)  && bus.car_in) ||
                       ((state == GRANT_OUT) && bus.car_out);

  // Timer restarts on every phase change and idles at zero in IDLE
  assign timer_limit = (state == CLEAR) ? CLEAR_LIM : OPEN_LIM;
  assign timer_clr   = (state == IDLE) ||
                       (grant_phase && (pass || at_limit)) ||
                       ((state == CLEAR) && at_limit);

  gate_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timer_clr),
    .limit    (timer_limit),
    .at_limit (at_limit)
  );

  // Arbitration FSM with registered gate, grant and strobe outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_srv    <= DIR_OUT;
      gate_up     <= 1'b0;
      grant_in    <= 1'b0;
      grant_out   <= 1'b0;
      cnt_en      <= 1'b0;
      cnt_up      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt_en      <= 1'b0;
      cnt_up      <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_in) begin
            state    <= GRANT_IN;
            gate_up  <= 1'b1;
            grant_in <= 1'b1;
          end else if (pick_out) begin
            state     <= GRANT_OUT;
            gate_up   <= 1'b1;
            grant_out <= 1'b1;
          end
        end
        GRANT_IN, GRANT_OUT: begin
          // A pass on the final cycle still wins over the timeout
          if (pass || at_limit) begin
            state       <= CLEAR;
            gate_up     <= 1'b0;
            grant_in    <= 1'b0;
            grant_out   <= 1'b0;
            last_srv    <= (state == GRANT_IN) ? DIR_IN : DIR_OUT;
            cnt_en      <= pass;
            cnt_up      <= pass && (state == GRANT_IN);
            timeout_err <= ~pass;
          end
        end
        CLEAR: begin
          if (at_limit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gate_up     = gate_up;
  assign bus.grant_in    = grant_in;
  assign bus.grant_out   = grant_out;
  assign bus.cnt_en      = cnt_en;
  assign bus.cnt_up      = cnt_up;
  assign bus.timeout_err = timeout_err;
  assign bus.state       = state;

`ifdef WRONG_WAY_ALARM_EN
  logic wrong_way, ww_evt;

  assign ww_evt = ((state == GRANT_IN)  && bus.car_out) ||
                  ((state == GRANT_OUT) && bus.car_in)  ||
                  (((state == IDLE) || (state == CLEAR)) && (bus.car_in || bus.car_out));

  // Sticky alarm for a pass pulse that does not match the granted lane
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrong_way <= 1'b0;
    end else if (ww_evt) begin
      wrong_way <= 1'b1;
    end
  end

  assign bus.wrong_way = wrong_way;
`endif

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed testbench for gate_arbiter: entry, full, empty, round-robin ties,
// grant timeout, pass-beats-timeout, reset mid-grant and (when
// WRONG_WAY_ALARM_EN is defined) the sticky wrong_way alarm.
module tb_gate_arbiter;
  import parking_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  gate_arbiter_if #(.CNT_W(3)) bus ();

  gate_arbiter #(
    .CNT_W        (3),
    .CAPACITY     (7),
    .OPEN_CYCLES  (1000),
    .CLEAR_CYCLES (50)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n clocks; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the edge that entered CLEAR; runs the 50-cycle holdoff
  task automatic wait_clear(input string tag);
    for (int i = 1; i <= 49; i++) begin
      step();
      if (i == 1) begin
        chk({tag, "_strobe_one_cycle"}, bus.cnt_en, 1'b0);
        chk({tag, "_timeout_one_cycle"}, bus.timeout_err, 1'b0);
      end
      if (i == 10) bus.car_in = 1'b1;
      if (i == 11) begin
        bus.car_in = 1'b0;
        chk({tag, "_clear_ignores_pass"}, bus.cnt_en, 1'b0);
      end
    end
    chk({tag, "_clear_state"}, bus.state, CLEAR);
    chk({tag, "_clear_gate"}, bus.gate_up, 1'b0);
    step();
    chk({tag, "_back_idle"}, bus.state, IDLE);
  endtask

  initial begin
    reset       = 1'b0;
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;
    bus.car_in  = 1'b0;
    bus.car_out = 1'b0;
    bus.count   = 3'd0;
    step(2);

    // Reset state
    chk("rst_gate_up", bus.gate_up, 1'b0);
    chk("rst_grant_in", bus.grant_in, 1'b0);
    chk("rst_grant_out", bus.grant_out, 1'b0);
    chk("rst_cnt_en", bus.cnt_en, 1'b0);
    chk("rst_cnt_up", bus.cnt_up, 1'b0);
    chk("rst_timeout", bus.timeout_err, 1'b0);
    chk("rst_state", bus.state, IDLE);
    reset     = 1'b1;
    bus.count = 3'd2;
    step();

    // Entry at count=2
    bus.req_in = 1'b1;
    chk("entry_full", bus.full, 1'b0);
    chk("entry_empty", bus.empty, 1'b0);
    step();
    chk("entry_grant_in", bus.grant_in, 1'b1);
    chk("entry_gate_up", bus.gate_up, 1'b1);
    chk("entry_grant_out", bus.grant_out, 1'b0);
    chk("entry_state", bus.state, GRANT_IN);
    bus.req_in = 1'b0;
    step(3);
    chk("entry_grant_holds", bus.grant_in, 1'b1);
    bus.car_out = 1'b1;
    step();
    bus.car_out = 1'b0;
    chk("entry_wrong_pass_no_cnt", bus.cnt_en, 1'b0);
    chk("entry_wrong_pass_grant", bus.grant_in, 1'b1);
    bus.car_in = 1'b1;
    step();
    bus.car_in = 1'b0;
    chk("entry_cnt_en", bus.cnt_en, 1'b1);
    chk("entry_cnt_up", bus.cnt_up, 1'b1);
    chk("entry_gate_drop", bus.gate_up, 1'b0);
    chk("entry_grant_drop", bus.grant_in, 1'b0);
    chk("entry_to_clear", bus.state, CLEAR);
    wait_clear("entry");

    // Full lot: entry refused, exit served
    bus.count  = 3'd7;
    bus.req_in = 1'b1;
    chk("full_flag", bus.full, 1'b1);
    chk("full_not_empty", bus.empty, 1'b0);
    step(2);
    chk("full_idle", bus.state, IDLE);
    chk("full_no_gate", bus.gate_up, 1'b0);
    chk("full_no_grant", bus.grant_in, 1'b0);
    bus.req_out = 1'b1;
    step();
    chk("full_grant_out", bus.grant_out, 1'b1);
    chk("full_gate_up", bus.gate_up, 1'b1);
    chk("full_grant_in_low", bus.grant_in, 1'b0);
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;
    bus.car_out = 1'b1;
    step();
    bus.car_out = 1'b0;
    chk("full_cnt_en", bus.cnt_en, 1'b1);
    chk("full_cnt_down", bus.cnt_up, 1'b0);
    chk("full_grant_drop", bus.grant_out, 1'b0);
    wait_clear("full");

    // Empty lot: exit refused
    bus.count   = 3'd0;
    bus.req_out = 1'b1;
    chk("empty_flag", bus.empty, 1'b1);
    chk("empty_not_full", bus.full, 1'b0);
    step(2);
    chk("empty_no_grant", bus.grant_out, 1'b0);
    chk("empty_idle", bus.state, IDLE);
    bus.req_out = 1'b0;

    // Round-robin ties after a fresh reset: IN, OUT, IN
    reset = 1'b0;
    step();
    reset       = 1'b1;
    bus.count   = 3'd3;
    bus.req_in  = 1'b1;
    bus.req_out = 1'b1;
    step();
    chk("tie1_grant_in", bus.grant_in, 1'b1);
    chk("tie1_grant_out", bus.grant_out, 1'b0);
    bus.car_in = 1'b1;
    step();
    bus.car_in = 1'b0;
    chk("tie1_cnt_en", bus.cnt_en, 1'b1);
    chk("tie1_cnt_up", bus.cnt_up, 1'b1);
    wait_clear("tie1");
    step();
    chk("tie2_grant_out", bus.grant_out, 1'b1);
    chk("tie2_grant_in", bus.grant_in, 1'b0);
    bus.car_out = 1'b1;
    step();
    bus.car_out = 1'b0;
    chk("tie2_cnt_en", bus.cnt_en, 1'b1);
    chk("tie2_cnt_up", bus.cnt_up, 1'b0);
    wait_clear("tie2");
    step();
    chk("tie3_grant_in", bus.grant_in, 1'b1);

    // Timeout: no car_in for OPEN_CYCLES cycles
    step(999);
    chk("tmo_still_granted", bus.grant_in, 1'b1);
    chk("tmo_not_yet", bus.timeout_err, 1'b0);
    step();
    chk("tmo_pulse", bus.timeout_err, 1'b1);
    chk("tmo_no_cnt_en", bus.cnt_en, 1'b0);
    chk("tmo_gate_drop", bus.gate_up, 1'b0);
    chk("tmo_to_clear", bus.state, CLEAR);
    wait_clear("tmo");
    step();
    chk("tmo_next_tie_out", bus.grant_out, 1'b1);

    // Pass on the last grant cycle beats the timeout
    step(999);
    chk("race_still_granted", bus.grant_out, 1'b1);
    bus.car_out = 1'b1;
    step();
    bus.car_out = 1'b0;
    chk("race_cnt_en", bus.cnt_en, 1'b1);
    chk("race_no_timeout", bus.timeout_err, 1'b0);
    chk("race_cnt_down", bus.cnt_up, 1'b0);
    wait_clear("race");

    // Reset during GRANT_OUT coincident with car_out
    bus.req_in = 1'b0;
    step();
    chk("rmg_grant_out", bus.grant_out, 1'b1);
    bus.car_out = 1'b1;
    reset       = 1'b0;
    step();
    bus.car_out = 1'b0;
    reset       = 1'b1;
    bus.req_out = 1'b0;
    chk("rmg_gate_up", bus.gate_up, 1'b0);
    chk("rmg_grant_out_low", bus.grant_out, 1'b0);
    chk("rmg_no_cnt_en", bus.cnt_en, 1'b0);
    chk("rmg_no_timeout", bus.timeout_err, 1'b0);
    chk("rmg_state", bus.state, IDLE);
    step();

`ifdef WRONG_WAY_ALARM_EN
    // Wrong-way pass during GRANT_OUT sets a sticky alarm
    chk("ww_after_reset", bus.wrong_way, 1'b0);
    bus.req_out = 1'b1;
    step();
    chk("ww_grant_out", bus.grant_out, 1'b1);
    bus.req_out = 1'b0;
    bus.car_in  = 1'b1;
    step();
    bus.car_in = 1'b0;
    chk("ww_set", bus.wrong_way, 1'b1);
    chk("ww_no_cnt_en", bus.cnt_en, 1'b0);
    chk("ww_grant_kept", bus.grant_out, 1'b1);
    step(3);
    chk("ww_sticky", bus.wrong_way, 1'b1);
    bus.car_out = 1'b1;
    step();
    bus.car_out = 1'b0;
    chk("ww_real_pass", bus.cnt_en, 1'b1);
    wait_clear("ww");
    chk("ww_sticky_idle", bus.wrong_way, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("ww_cleared", bus.wrong_way, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_arbiter.md
Name: gate_arbiter

Overview:
- Sequences a single shared barrier gate between an entry requester and an exit requester in the parking-lot controller.
- Grants the lane to one direction at a time and raises the gate.
- Waits for the vehicle-pass pulse from the in/out FSM, then issues the enable/updown strobe to the 3-bit occupancy counter.
- Refuses entry when the lot is full and refuses exit when it is empty.

Parameters:
- CNT_W, 3: occupancy count width.
- CAPACITY, 7: maximum occupancy; entry is refused when count >= CAPACITY.
- OPEN_CYCLES, 1000: maximum cycles the gate stays granted without a pass pulse.
- CLEAR_CYCLES, 50: gate-closed holdoff after each grant, before the next arbitration.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_in  in  1  entry request level, debounced, active-high.
- req_out  in  1  exit request level, debounced, active-high.
- car_in  in  1  one-cycle pulse from the FSM: vehicle completed entry.
- car_out  in  1  one-cycle pulse from the FSM: vehicle completed exit.
- count  in  CNT_W  current occupancy from the counter.
- gate_up  out  1  barrier raise command.
- grant_in  out  1  lane granted to entry.
- grant_out  out  1  lane granted to exit.
- cnt_en  out  1  counter enable strobe, one cycle.
- cnt_up  out  1  counter direction: 1 = increment, 0 = decrement. Valid with cnt_en.
- full  out  1  count >= CAPACITY (combinational).
- empty  out  1  count == 0 (combinational).
- timeout_err  out  1  one-cycle pulse when a grant expires without a pass.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, timer=0, last_srv=OUT.
  - All registered outputs are 0: gate_up, grant_in, grant_out, cnt_en, cnt_up, timeout_err.
  - Reset mid-grant drops the gate in the same edge and issues no counter strobe.
- Eligibility:
  - vin = req_in & ~full.
  - vout = req_out & ~empty.
- IDLE:
  - gate_up=0.
  - vin only -> GRANT_IN. vout only -> GRANT_OUT.
  - Both eligible: the direction opposite last_srv wins (round-robin). After reset the first tie goes to IN.
  - grant_x and gate_up are asserted in the first cycle of GRANT_x, i.e. one cycle after the request is sampled. The timer loads 0.
- GRANT_IN:
  - gate_up=1, grant_in=1, timer increments every cycle.
  - car_in seen -> next cycle cnt_en=1, cnt_up=1 for exactly one cycle. Same edge: last_srv=IN, state -> CLEAR.
  - timer reaches OPEN_CYCLES-1 with no car_in -> timeout_err=1 for one cycle, state -> CLEAR, no cnt_en. last_srv=IN, so a stuck requester cannot starve the other direction.
  - car_out during GRANT_IN is ignored (see optional feature).
  - Dropping req_in does not cancel the grant; only a pass or a timeout ends it.
- GRANT_OUT: mirror of GRANT_IN, using car_out, cnt_up=0, grant_out and last_srv=OUT.
- CLEAR:
  - gate_up=0, grants=0, timer counts CLEAR_CYCLES cycles, then -> IDLE.
  - Pass pulses are ignored in this state.
- Simultaneous pass and timeout on the same cycle: the pass wins. cnt_en is issued and timeout_err is not.
- cnt_en and timeout_err are never high in the same cycle, and each is high for exactly one cycle per grant.
- full and empty follow count combinationally. Eligibility is rechecked only in IDLE.
- Counter saturation is guaranteed by construction: cnt_up=1 is never issued at count >= CAPACITY, and decrement is never issued at count == 0.

Optional Feature:
- Macro: WRONG_WAY_ALARM_EN.
- Defined:
  - Adds output wrong_way (1 bit), sticky.
  - Set on car_out during GRANT_IN, on car_in during GRANT_OUT, or on any pass pulse in IDLE or CLEAR.
  - Cleared only by reset.
  - A wrong-way event issues no cnt_en and does not end the grant.
- Undefined: the wrong_way port is absent, and such pulses are silently ignored.

Decomposition:
- Package parking_pkg holds:
  - state enum {IDLE, GRANT_IN, GRANT_OUT, CLEAR}.
  - direction encoding DIR_IN=1, DIR_OUT=0, matching the counter's updown sense.
  - default CNT_W=3.
- One sub-module, gate_timer: a synchronous up-counter with load-zero and a terminal-count compare against a runtime limit. A single instance is shared by the grant and clear phases.

Test Plan:
- Entry: count=2, req_in=1 -> gate_up=1, grant_in=1 one cycle later. car_in pulse -> cnt_en=1, cnt_up=1 for exactly one cycle -> CLEAR for 50 cycles, gate_up=0.
- Full: count=7, req_in=1, req_out=0 -> stays IDLE, gate_up=0, full=1, no grant. Then req_out=1 -> grant_out.
- Empty: count=0, req_out=1 -> no grant, empty=1.
- Tie: count=3, req_in and req_out high continuously. After reset the grant sequence alternates IN, OUT, IN, with each grant separated by CLEAR.
- Timeout: grant_in held with no car_in for 1000 cycles -> timeout_err pulse, no cnt_en, gate_up drops. The next tie goes to OUT.
- Reset mid-grant: reset=0 during GRANT_OUT, coincident with car_out -> all outputs 0 after the edge, no cnt_en. With WRONG_WAY_ALARM_EN defined, car_in during GRANT_OUT -> wrong_way=1 and stays high until reset.
